// File: rtl/audio_byte_fifo.sv
// audio_byte_fifo: byte-wide synchronous FIFO between the storage loader and the I2S transmitter
//   Optional build macro: AUDIO_FIFO_STATS_EN adds saturating 16-bit drop/ignore counters.
//   i_clk, i_rst_n (async, active-low), i_flush (sync clear)
//   i_wr_en/i_wr_data -> o_full, o_overflow, o_ovf_count
//   i_rd_en -> o_rd_data/o_rd_valid (registered, one cycle later), o_empty, o_underflow, o_unf_count
//   o_level: bytes stored; o_refill_req: hysteresis request between LOW_WM and HIGH_WM
module audio_byte_fifo #(
  parameter int DEPTH   = 1024,
  parameter int LOW_WM  = 256,
  parameter int HIGH_WM = 768
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_wr_en,
  input  logic [7:0]               i_wr_data,
  output logic                     o_full,
  input  logic                     i_rd_en,
  output logic [7:0]               o_rd_data,
  output logic                     o_rd_valid,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_refill_req,
  output logic                     o_overflow,
  output logic                     o_underflow,
  output logic [15:0]              o_ovf_count,
  output logic [15:0]              o_unf_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_LOW   = (AW+1)'(LOW_WM);
  localparam logic [AW:0] L_HIGH  = (AW+1)'(HIGH_WM);
  typedef enum logic {S_IDLE, S_REQ} state_t;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_level, w_level_next;
  logic [7:0]    r_rd_data;
  logic          r_rd_valid, r_empty, r_full, r_ovf, r_unf;
  logic          w_wr_acc, w_rd_acc, w_wr_drop, w_rd_drop;
  state_t        r_state, w_state_next;
  // Acceptance uses only the registered flags, so a same-cycle read never frees room
  // for a write and a same-cycle write never satisfies a read.
  assign w_wr_acc  = i_wr_en && !r_full && !i_flush;
  assign w_rd_acc  = i_rd_en && !r_empty && !i_flush;
  assign w_wr_drop = i_wr_en && r_full && !i_flush;
  assign w_rd_drop = i_rd_en && r_empty && !i_flush;
  assign w_level_next = i_flush ? '0 : r_level + (AW+1)'(w_wr_acc) - (AW+1)'(w_rd_acc);
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= i_wr_data;
  end
  // Registered RAM read port; holds its value whenever no read is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rd_data <= '0;
    else if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr];
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_wr_ptr   <= i_flush ? '0 : r_wr_ptr + AW'(w_wr_acc);
      r_rd_ptr   <= i_flush ? '0 : r_rd_ptr + AW'(w_rd_acc);
      r_level    <= w_level_next;
      r_empty    <= w_level_next == '0;
      r_full     <= w_level_next == L_DEPTH;
      r_rd_valid <= w_rd_acc;
      r_ovf      <= w_wr_drop;
      r_unf      <= w_rd_drop;
    end
  end
  // Refill hysteresis evaluated on the next level so the request moves together with o_level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_REQ;
    else r_state <= w_state_next;
  end
  always_comb begin
    w_state_next = i_flush ? S_REQ :
                   (r_state == S_IDLE && w_level_next < L_LOW)  ? S_REQ :
                   (r_state == S_REQ && w_level_next >= L_HIGH) ? S_IDLE : r_state;
  end
  always_comb begin
    o_refill_req = r_state == S_REQ;
  end
`ifdef AUDIO_FIFO_STATS_EN
  logic [15:0] r_ovf_count, r_unf_count;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf_count <= '0;
      r_unf_count <= '0;
    end else if (i_flush) begin
      r_ovf_count <= '0;
      r_unf_count <= '0;
    end else begin
      if (w_wr_drop && r_ovf_count != 16'hFFFF) r_ovf_count <= r_ovf_count + 16'd1;
      if (w_rd_drop && r_unf_count != 16'hFFFF) r_unf_count <= r_unf_count + 16'd1;
    end
  end
  assign o_ovf_count = r_ovf_count;
  assign o_unf_count = r_unf_count;
`else
  assign o_ovf_count = '0;
  assign o_unf_count = '0;
`endif
  assign o_full      = r_full;
  assign o_empty     = r_empty;
  assign o_level     = r_level;
  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;
  assign o_overflow  = r_ovf;
  assign o_underflow = r_unf;
endmodule
